// File: rtl/ic_tester_pkg.sv
// Device table for the 74xx IC tester: codes, truth tables, pin masks and
// the mapping from (device code, vector index) to the GPIO drive word.
package ic_tester_pkg;

    localparam logic [3:0] CODE_NAND = 4'd0;
    localparam logic [3:0] CODE_AND  = 4'd1;
    localparam logic [3:0] CODE_OR   = 4'd2;
    localparam logic [3:0] CODE_XOR  = 4'd3;
    localparam logic [3:0] CODE_XNOR = 4'd4;
    localparam logic [3:0] CODE_NOR  = 4'd5;
    localparam logic [3:0] CODE_NOT  = 4'd6;
    localparam logic [3:0] VALID_MAX = 4'd6;

    // gpio index = DIP pin - 1; GND (6) and VCC (13) appear in no mask
    localparam logic [13:0] GATE_A_MASK   = 14'h0909;
    localparam logic [13:0] GATE_B_MASK   = 14'h1212;
    localparam logic [13:0] GATE_OUT_MASK = 14'h04A4;
    localparam logic [13:0] NOR_A_MASK    = 14'h0492;
    localparam logic [13:0] NOR_B_MASK    = 14'h0924;
    localparam logic [13:0] NOR_OUT_MASK  = 14'h1209;
    localparam logic [13:0] NOT_IN_MASK   = 14'h1515;
    localparam logic [13:0] NOT_OUT_MASK  = 14'h0AAA;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

    // Bit v holds the expected output level for vector v.
    function automatic logic [3:0] exp_table(input logic [3:0] code);
        case (code)
            CODE_NAND: exp_table = 4'b0111;
            CODE_AND:  exp_table = 4'b1000;
            CODE_OR:   exp_table = 4'b1110;
            CODE_XOR:  exp_table = 4'b0110;
            CODE_XNOR: exp_table = 4'b1001;
            CODE_NOR:  exp_table = 4'b0001;
            CODE_NOT:  exp_table = 4'b0101;
            default:   exp_table = 4'b0000;
        endcase
    endfunction

    function automatic logic [13:0] in_mask(input logic [3:0] code);
        if (code <= CODE_XNOR)
            in_mask = GATE_A_MASK | GATE_B_MASK;
        else if (code == CODE_NOR)
            in_mask = NOR_A_MASK | NOR_B_MASK;
        else if (code == CODE_NOT)
            in_mask = NOT_IN_MASK;
        else
            in_mask = 14'd0;
    endfunction

    function automatic logic [13:0] out_mask(input logic [3:0] code);
        if (code <= CODE_XNOR)
            out_mask = GATE_OUT_MASK;
        else if (code == CODE_NOR)
            out_mask = NOR_OUT_MASK;
        else if (code == CODE_NOT)
            out_mask = NOT_OUT_MASK;
        else
            out_mask = 14'd0;
    endfunction

    // A = v[1], B = v[0] on every gate; the inverter only sees v[0].
    function automatic logic [13:0] drive_word(input logic [3:0] code, input logic [1:0] v);
        logic [13:0] a_word;
        logic [13:0] b_word;
        a_word = {14{v[1]}};
        b_word = {14{v[0]}};
        if (code <= CODE_XNOR)
            drive_word = (a_word & GATE_A_MASK) | (b_word & GATE_B_MASK);
        else if (code == CODE_NOR)
            drive_word = (a_word & NOR_A_MASK) | (b_word & NOR_B_MASK);
        else if (code == CODE_NOT)
            drive_word = b_word & NOT_IN_MASK;
        else
            drive_word = 14'd0;
    endfunction

endpackage

// File: rtl/ic_pin_sync.sv
// Two-flop synchronizer bringing the asynchronous GPIO read-back into clk.
module ic_pin_sync #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ic_test_sequencer.sv
// Functional tester for one 14-pin 74xx IC: drives 4 vectors, samples outputs.
// Build option STOP_ON_FAIL_EN: end the test at the first mismatching vector.
module ic_test_sequencer
    import ic_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 50,
    parameter int NUM_VECTORS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  number,
    input  logic [13:0] pin_in,
    output logic [13:0] pin_out,
    output logic [13:0] pin_oe,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [13:0] fail_pins
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    LAST_VEC    = 2'(NUM_VECTORS - 1);

    state_t        state;
    logic [3:0]    code;
    logic [1:0]    vec;
    logic [CW-1:0] settle_cnt;
    logic [13:0]   pin_sync;

    logic [3:0]    exp_bits;
    logic [13:0]   exp_word;
    logic [13:0]   mismatch;
    logic [3:0]    fail_mask_nxt;
    logic          last_sample;

    ic_pin_sync #(.W(14)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_in),
        .q   (pin_sync)
    );

    // Every output pin of the device shares one expected level per vector.
    always_comb begin
        exp_bits      = exp_table(code);
        exp_word      = exp_bits[vec] ? out_mask(code) : 14'd0;
        mismatch      = (pin_sync ^ exp_word) & out_mask(code);
        fail_mask_nxt = (|mismatch) ? (fail_mask | (4'b0001 << vec)) : fail_mask;
`ifdef STOP_ON_FAIL_EN
        last_sample   = (vec == LAST_VEC) || (|mismatch);
`else
        last_sample   = (vec == LAST_VEC);
`endif
    end

    // start is a one-cycle request honoured only in IDLE; done marks the
    // single cycle spent in DONE, and busy drops on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            code       <= 4'd0;
            vec        <= 2'd0;
            settle_cnt <= '0;
            pin_out    <= 14'd0;
            pin_oe     <= 14'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 4'd0;
            fail_pins  <= 14'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        code      <= number;
                        vec       <= 2'd0;
                        fail_mask <= 4'd0;
                        fail_pins <= 14'd0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        if (number > VALID_MAX) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    pin_out    <= drive_word(code, vec);
                    pin_oe     <= in_mask(code);
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST)
                        state <= SAMPLE;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    fail_mask <= fail_mask_nxt;
                    fail_pins <= fail_pins | mismatch;
                    if (last_sample) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        pass    <= (fail_mask_nxt == 4'd0);
                        pin_out <= 14'd0;
                        pin_oe  <= 14'd0;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Bench for ic_test_sequencer with a behavioural 74xx chip on the GPIO pins.
// Honours STOP_ON_FAIL_EN when computing expected results.
module tb_ic_test_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  number;
    logic [13:0] pin_in;
    logic [13:0] pin_out;
    logic [13:0] pin_oe;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  fail_mask;
    logic [13:0] fail_pins;

    int n_checks = 0;
    int n_errors = 0;
    int done_count = 0;
    int chip = 0;
    int fault_kind = 0;
    int fault_pin = 0;
    logic [3:0] cur_code = 4'd0;
    logic mon_en = 1'b0;

    logic [18:0] exp_q[$];
    int          lat_q[$];

    ic_test_sequencer #(.SETTLE_CYCLES(4), .NUM_VECTORS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .number    (number),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .fail_pins (fail_pins)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_count++;

    // ---------------- behavioural chip ----------------
    function automatic logic gate2(input int dev, input logic a, input logic b);
        case (dev)
            0: gate2 = ~(a & b);
            1: gate2 = a & b;
            2: gate2 = a | b;
            3: gate2 = a ^ b;
            4: gate2 = ~(a ^ b);
            default: gate2 = ~(a | b);
        endcase
    endfunction

    function automatic logic [13:0] chip_pins(input int dev, input logic [13:0] pad,
                                              input int fpin, input int fkind);
        int ga[4];
        int gb[4];
        int gy[4];
        int ia[6];
        int iy[6];
        logic [13:0] r;
        r = pad;
        ia = '{0, 2, 4, 8, 10, 12};
        iy = '{1, 3, 5, 7, 9, 11};
        if (dev == 5) begin
            ga = '{1, 4, 7, 10};
            gb = '{2, 5, 8, 11};
            gy = '{0, 3, 9, 12};
        end else begin
            ga = '{0, 3, 8, 11};
            gb = '{1, 4, 9, 12};
            gy = '{2, 5, 7, 10};
        end
        if (dev <= 5) begin
            for (int i = 0; i < 4; i++) r[gy[i]] = gate2(dev, pad[ga[i]], pad[gb[i]]);
        end else if (dev == 6) begin
            for (int i = 0; i < 6; i++) r[iy[i]] = ~pad[ia[i]];
        end
        if (fkind == 1) r[fpin] = 1'b0;
        else if (fkind == 2) r[fpin] = 1'b1;
        return r;
    endfunction

    always_comb pin_in = chip_pins(chip, pin_out & pin_oe, fault_pin, fault_kind);

    function automatic logic [13:0] dev_out_mask(input logic [3:0] code);
        if (code <= 4'd4) return 14'h04A4;
        else if (code == 4'd5) return 14'h1209;
        else if (code == 4'd6) return 14'h0AAA;
        else return 14'h3FFF;
    endfunction

    function automatic logic [18:0] pack_res(input logic p, input logic [3:0] m, input logic [13:0] pins);
        return {p, m, pins};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Power pins never driven; an output pin (or anything, for an invalid code) never driven.
    always @(negedge clk) begin
        if (mon_en) begin
            check("oe_power", {18'd0, pin_oe & 14'h2040}, 32'd0);
            check("oe_outpin", {18'd0, pin_oe & dev_out_mask(cur_code)}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int pre);
        int n;
        logic got;
        logic [18:0] exp_res;
        int exp_lat;
        n = pre;
        got = 1'b0;
        while (n < 400 && !got) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1'b1;
        end
        check("done_seen", {31'd0, got}, 32'd1);
        exp_res = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        if (got) begin
            check("result", {13'd0, pass, fail_mask, fail_pins}, {13'd0, exp_res});
            check("latency", n, exp_lat);
            check("oe_at_done", {18'd0, pin_oe}, 32'd0);
            @(negedge clk);
            check("done_pulse", {31'd0, done}, 32'd0);
            check("busy_after", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic launch(input logic [3:0] code, input int dev, input int fkind, input int fpin,
                          input logic [18:0] exp_res, input int exp_lat);
        chip = dev;
        fault_kind = fkind;
        fault_pin = fpin;
        @(posedge clk); #1;
        start = 1'b1;
        number = code;
        cur_code = code;
        exp_q.push_back(exp_res);
        lat_q.push_back(exp_lat);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_test(input logic [3:0] code, input int dev, input int fkind, input int fpin,
                            input logic [18:0] exp_res, input int exp_lat);
        launch(code, dev, fkind, fpin, exp_res, exp_lat);
        wait_done(0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc0;
        logic [3:0] rc;
        rst = 1'b1;
        start = 1'b0;
        number = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_oe", {18'd0, pin_oe}, 32'd0);
        check("rst_out", {18'd0, pin_out}, 32'd0);
        check("rst_flags", {28'd0, busy, done, pass, |fail_mask}, 32'd0);
        check("rst_pins", {18'd0, fail_pins}, 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int c = 0; c <= 6; c++)
            run_test(4'(c), c, 0, 0, pack_res(1'b1, 4'd0, 14'd0), 25);

`ifdef STOP_ON_FAIL_EN
        run_test(4'd6, 6, 1, 5, pack_res(1'b0, 4'b0001, 14'h0020), 7);
        run_test(4'd6, 6, 2, 5, pack_res(1'b0, 4'b0010, 14'h0020), 13);
        run_test(4'd3, 0, 0, 0, pack_res(1'b0, 4'b0001, 14'h04A4), 7);
`else
        run_test(4'd6, 6, 1, 5, pack_res(1'b0, 4'b0101, 14'h0020), 25);
        run_test(4'd6, 6, 2, 5, pack_res(1'b0, 4'b1010, 14'h0020), 25);
        run_test(4'd3, 0, 0, 0, pack_res(1'b0, 4'b0001, 14'h04A4), 25);
`endif
        run_test(4'd9, 0, 0, 0, pack_res(1'b0, 4'd0, 14'd0), 1);
        run_test(4'd15, 0, 0, 0, pack_res(1'b0, 4'd0, 14'd0), 1);

        // start while busy and a code change mid-test are both ignored
        dc0 = done_count;
        launch(4'd0, 0, 0, 0, pack_res(1'b1, 4'd0, 14'd0), 25);
        repeat (10) @(negedge clk);
        check("busy_mid", {31'd0, busy}, 32'd1);
        start = 1'b1;
        number = 4'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(11);
        repeat (30) @(negedge clk);
        check("one_done", done_count - dc0, 1);

        // reset in the third SETTLE cycle of vector 1 (cycle 10)
        chip = 5;
        fault_kind = 0;
        @(posedge clk); #1;
        start = 1'b1;
        number = 4'd5;
        cur_code = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("oe_pre_rst", {18'd0, pin_oe}, 32'h0DB6);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_oe", {18'd0, pin_oe}, 32'd0);
        check("abort_out", {18'd0, pin_out}, 32'd0);
        check("abort_flags", {28'd0, busy, done, pass, |fail_mask}, 32'd0);
        check("abort_pins", {18'd0, fail_pins}, 32'd0);
        run_test(4'd5, 5, 0, 0, pack_res(1'b1, 4'd0, 14'd0), 25);

        // start on the same edge as reset: reset wins
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        number = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", {31'd0, busy}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            rc = 4'($urandom_range(0, 6));
            run_test(rc, int'(rc), 0, 0, pack_res(1'b1, 4'd0, 14'd0), 25);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
